// File: rtl/jk_cmd_sequencer_if.sv
// jk_cmd_sequencer_if
//   Command channel for the JK command sequencer (val/rdy handshake).
//   val  : command valid (master -> slave)
//   rdy  : command ready (slave -> master); transfer when val && rdy
//   op   : {J,K} command: 00 hold, 01 reset, 10 set, 11 toggle
//   cnt  : number of cycles to drive op (0 = no-op)
interface jk_cmd_sequencer_if #(
   parameter int p_cnt_nbits = 4
);
   logic                   val;
   logic                   rdy;
   logic [1:0]             op;
   logic [p_cnt_nbits-1:0] cnt;

   modport master (output val, output op, output cnt, input rdy);
   modport slave  (input val, input op, input cnt, output rdy);
endinterface

// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer
//   Upstream driver for a JK flip-flop stage. Accepts {J,K} commands with a
//   repeat count and drives the flop's J (a) and K (b) inputs for exactly that
//   many cycles, starting the cycle after the transfer. A shadow copy of the
//   flop output is kept so downstream logic can predict q without sampling it.
//
// Ports
//   clk      : clock, all state updates on posedge
//   reset    : synchronous active-high reset
//   cmd      : command channel (slave side: val/op/cnt in, rdy out)
//   a, b     : J and K inputs of the driven flop
//   busy     : high while a command is being driven
//   q_model  : predicted flop q after the most recent edge
//   q_known  : high once q_model is guaranteed to match the flop
module jk_cmd_sequencer #(
   parameter int p_cnt_nbits = 4
) (
   input  logic                clk,
   input  logic                reset,
   jk_cmd_sequencer_if.slave   cmd,
   output logic                a,
   output logic                b,
   output logic                busy,
   output logic                q_model,
   output logic                q_known
);

   localparam logic [0:0] STATE_IDLE = 1'b0;
   localparam logic [0:0] STATE_RUN  = 1'b1;

   logic [0:0]             state;
   logic [0:0]             state_next;
   logic [1:0]             op;
   logic [1:0]             op_next;
   logic [p_cnt_nbits-1:0] remaining;
   logic [p_cnt_nbits-1:0] remaining_next;

   logic rdy;
   logic xfer;
   logic load;
   logic last;

   // All outputs decode registered state only.
   assign busy = (state == STATE_RUN);
   assign a    = busy & op[1];
   assign b    = busy & op[0];
   assign last = busy && (remaining == p_cnt_nbits'(1));
   assign rdy  = (state == STATE_IDLE) || last;

   assign cmd.rdy = rdy;
   assign xfer    = cmd.val && rdy;
   // Zero-count commands are consumed without ever entering RUN.
   assign load    = xfer && (cmd.cnt != '0);

   always_comb begin
      state_next     = state;
      op_next        = op;
      remaining_next = remaining;
      unique case (state)
         STATE_IDLE: begin
            if (load) begin
               state_next     = STATE_RUN;
               op_next        = cmd.op;
               remaining_next = cmd.cnt;
            end
         end
         default: begin
            // remaining is >= 1 throughout RUN, so this never wraps.
            remaining_next = remaining - p_cnt_nbits'(1);
            if (last) begin
               if (load) begin
                  // Back-to-back reload: no idle bubble between commands.
                  op_next        = cmd.op;
                  remaining_next = cmd.cnt;
               end else begin
                  state_next = STATE_IDLE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= STATE_IDLE;
         op        <= 2'b00;
         remaining <= '0;
         q_model   <= 1'b0;
         q_known   <= 1'b0;
      end else begin
         state     <= state_next;
         op        <= op_next;
         remaining <= remaining_next;
         // Shadow flop follows the {J,K} actually presented this cycle.
         if (state == STATE_RUN) begin
            case (op)
               2'b01: begin
                  q_model <= 1'b0;
                  q_known <= 1'b1;
               end
               2'b10: begin
                  q_model <= 1'b1;
                  q_known <= 1'b1;
               end
               2'b11: q_model <= ~q_model;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
module tb_jk_cmd_sequencer;

   localparam int NB = 4;

   logic clk;
   logic reset;
   logic a;
   logic b;
   logic busy;
   logic q_model;
   logic q_known;

   jk_cmd_sequencer_if #(.p_cnt_nbits(NB)) cmd_if ();

   jk_cmd_sequencer #(.p_cnt_nbits(NB)) dut (
      .clk     (clk),
      .reset   (reset),
      .cmd     (cmd_if),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .q_model (q_model),
      .q_known (q_known)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total;
   int bad;

   // Reference model: a queue holding the {J,K} value for every drive cycle
   // still owed, plus the abstract flop value and whether it is known.
   logic [1:0] pend[$];
   logic       mq;
   logic       mk;

   function automatic logic model_rdy();
      return pend.size() <= 1;
   endfunction

   // Expected {a, b, busy, rdy, q_model, q_known}.
   function automatic logic [5:0] model_vec();
      if (pend.size() > 0)
         return {pend[0][1], pend[0][0], 1'b1, pend.size() == 1, mq, mk};
      return {3'b000, 1'b1, mq, mk};
   endfunction

   function automatic logic [5:0] dut_vec();
      return {a, b, busy, cmd_if.rdy, q_model, q_known};
   endfunction

   // One clock: capture the inputs the DUT sees, advance the model across the
   // edge, then return to the falling edge where outputs are sampled.
   task automatic tick();
      logic       r;
      logic       x;
      logic [1:0] o;
      int         n;
      r = reset;
      x = cmd_if.val && model_rdy();
      o = cmd_if.op;
      n = int'(cmd_if.cnt);
      @(posedge clk);
      if (r) begin
         pend.delete();
         mq = 1'b0;
         mk = 1'b0;
      end else begin
         if (pend.size() > 0) begin
            case (pend[0])
               2'b01: begin mq = 1'b0; mk = 1'b1; end
               2'b10: begin mq = 1'b1; mk = 1'b1; end
               2'b11: mq = ~mq;
               default: ;
            endcase
            void'(pend.pop_front());
         end
         if (x) for (int i = 0; i < n; i++) pend.push_back(o);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cmd_if.val = 1'b0;
      cmd_if.op  = 2'b00;
      cmd_if.cnt = '0;
      @(negedge clk);
      tick();
      tick();
      reset = 1'b0;
      total++;
      if (dut_vec() !== 6'b000100) begin
         bad++;
         $display("FAIL reset_state got=%b want=%b", dut_vec(), 6'b000100);
      end
      total++;
      if (dut_vec() !== model_vec()) begin
         bad++;
         $display("FAIL reset_model got=%b want=%b", dut_vec(), model_vec());
      end
   endtask

   task automatic test_set_once();
      cmd_if.val = 1'b1;
      cmd_if.op  = 2'b10;
      cmd_if.cnt = 4'd1;
      tick();
      cmd_if.val = 1'b0;
      total++;
      if ({a, b, busy} !== 3'b101 || dut_vec() !== model_vec()) begin
         bad++;
         $display("FAIL set_drive got=%b want=%b", dut_vec(), model_vec());
      end
      tick();
      total++;
      if ({a, b, busy, q_model, q_known} !== 5'b00011) begin
         bad++;
         $display("FAIL set_result got=%b want=%b", {a, b, busy, q_model, q_known}, 5'b00011);
      end
   endtask

   task automatic test_toggle();
      logic [2:0] qpat;
      qpat = 3'b010;
      cmd_if.val = 1'b1;
      cmd_if.op  = 2'b11;
      cmd_if.cnt = 4'd3;
      tick();
      cmd_if.val = 1'b0;
      for (int i = 0; i < 3; i++) begin
         total++;
         if ({a, b, busy} !== 3'b111 || dut_vec() !== model_vec()) begin
            bad++;
            $display("FAIL toggle_drive[%0d] got=%b want=%b", i, dut_vec(), model_vec());
         end
         tick();
         total++;
         if (q_model !== qpat[2-i] || q_known !== 1'b1) begin
            bad++;
            $display("FAIL toggle_q[%0d] got=%b%b want=%b1", i, q_model, q_known, qpat[2-i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] abr[4];
      abr[0] = 3'b010;
      abr[1] = 3'b011;
      abr[2] = 3'b101;
      abr[3] = 3'b001;
      cmd_if.val = 1'b1;
      cmd_if.op  = 2'b01;
      cmd_if.cnt = 4'd2;
      tick();
      cmd_if.op  = 2'b10;
      cmd_if.cnt = 4'd1;
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({a, b, cmd_if.rdy} !== abr[i] || dut_vec() !== model_vec()) begin
            bad++;
            $display("FAIL b2b[%0d] got=%b want=%b", i, {a, b, cmd_if.rdy}, abr[i]);
         end
         if (i == 1) begin
            tick();
            cmd_if.val = 1'b0;
         end else begin
            tick();
         end
      end
   endtask

   task automatic test_zero_cnt();
      logic q0;
      q0 = q_model;
      cmd_if.val = 1'b1;
      cmd_if.op  = 2'b11;
      cmd_if.cnt = 4'd0;
      total++;
      if (cmd_if.rdy !== 1'b1) begin
         bad++;
         $display("FAIL zero_rdy got=%b want=1", cmd_if.rdy);
      end
      tick();
      cmd_if.val = 1'b0;
      tick();
      total++;
      if ({a, b, busy} !== 3'b000 || q_model !== q0) begin
         bad++;
         $display("FAIL zero_cnt got=%b q=%b want=000 q=%b", {a, b, busy}, q_model, q0);
      end
   endtask

   task automatic test_reset_mid_run();
      cmd_if.val = 1'b1;
      cmd_if.op  = 2'b11;
      cmd_if.cnt = 4'd15;
      tick();
      cmd_if.val = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      total++;
      if ({a, b, busy, cmd_if.rdy} !== 4'b1110) begin
         bad++;
         $display("FAIL mid_run got=%b want=1110", {a, b, busy, cmd_if.rdy});
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++;
      if ({a, b, busy, cmd_if.rdy, q_known} !== 5'b00010) begin
         bad++;
         $display("FAIL mid_reset got=%b want=00010", {a, b, busy, cmd_if.rdy, q_known});
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         reset      = ($urandom_range(0, 39) == 0);
         cmd_if.val = ($urandom_range(0, 2) != 0);
         cmd_if.op  = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 4) == 0)      cmd_if.cnt = 4'd0;
         else if ($urandom_range(0, 5) == 0) cmd_if.cnt = 4'($urandom_range(1, 15));
         else                                cmd_if.cnt = 4'($urandom_range(1, 3));
         total++;
         if (dut_vec() !== model_vec()) begin
            bad++;
            $display("FAIL random[%0d] got=%b want=%b", i, dut_vec(), model_vec());
         end
         tick();
      end
      reset      = 1'b0;
      cmd_if.val = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      mq    = 1'b0;
      mk    = 1'b0;
      test_reset();
      test_set_once();
      test_toggle();
      test_back_to_back();
      test_zero_cnt();
      test_reset_mid_run();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
